// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit word memory with programmable wait states
// and read-modify-write for byte/halfword stores.
// Optional alignment checking is enabled by defining MEM_RESPONDER_ALIGN_CHK_EN.
module mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_MERGE = 3'd3,
    S_WRITE = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] idx_c;
  logic [31:0]   rd_word_c;
  logic [31:0]   lane_c;
  logic [31:0]   merge_c;
  logic          bad_c;
  logic          mem_we_c;
  logic [31:0]   mem_wdata_c;

  // Word index wraps modulo DEPTH; upper address bits fall away in the cast.
  assign idx_c     = AW'(addr_q >> 2);
  assign rd_word_c = mem_q[idx_c];

  // Requests that take the error path instead of touching memory.
  always_comb begin
    bad_c = (size_q == SZ_RSVD);
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    if ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00)) bad_c = 1'b1;
    if ((size_q == SZ_HALF) && addr_q[0])              bad_c = 1'b1;
`endif
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    lane_c  = rd_word_c;
    merge_c = word_q;
    case (size_q)
      SZ_BYTE: begin
        lane_c = {24'd0, rd_word_c[{addr_q[1:0], 3'b000} +: 8]};
        merge_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        lane_c = {16'd0, rd_word_c[{addr_q[1], 4'b0000} +: 16]};
        merge_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (bad_c)                             state_d = S_RESP;
          else if (wr_q && (size_q == SZ_WORD))  state_d = S_WRITE;
          else                                   state_d = S_READ;
        end
      end
      S_READ:  state_d = wr_q ? S_MERGE : S_RESP;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rdata_d     = rdata_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = word_q;
    ack_d       = (state_d == S_RESP);
    err_d       = (state_d == S_RESP) && bad_c;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wr_d    = wr;
          size_d  = size;
          wdata_d = wdata;
          cnt_d   = CW'(WAIT_STATES);
        end
      end
      S_WAIT:  if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      S_READ: begin
        if (wr_q) word_d  = rd_word_c;
        else      rdata_d = lane_c;
      end
      S_MERGE: word_d = merge_c;
      S_WRITE: begin
        mem_we_c    = 1'b1;
        mem_wdata_c = (size_q == SZ_WORD) ? wdata_q : word_q;
      end
      default: ;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; a write lands only on the edge leaving WRITE.
  always_ff @(posedge Clk) begin
    if (mem_we_c) mem_q[idx_c] <= mem_wdata_c;
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with 2 wait states, one with none,
// checked every cycle against a transaction-level model plus literal values.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int NI    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [NI];
  logic        wr    [NI];
  logic [1:0]  size  [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        ack   [NI];
  logic        busy  [NI];
  logic        err   [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
    .Clk(clk), .reset(rst_n), .req(req[0]), .wr(wr[0]), .size(size[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]),
    .busy(busy[0]), .err(err[0])
  );

  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .Clk(clk), .reset(rst_n), .req(req[1]), .wr(wr[1]), .size(size[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]),
    .busy(busy[1]), .err(err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] m_mem  [NI][DEPTH];
  logic        m_act  [NI];
  int          m_t    [NI];
  int          m_lat  [NI];
  logic        m_wr   [NI];
  logic [1:0]  m_size [NI];
  logic [31:0] m_addr [NI];
  logic [31:0] m_wd   [NI];
  logic        m_bad  [NI];
  logic        e_ack  [NI];
  logic        e_busy [NI];
  logic        e_err  [NI];
  logic [31:0] e_rdata[NI];
  int          m_idx;

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
    logic b;
    b = (sz == 2'd3);
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    if (sz == 2'd0 && (a % 4) != 0) b = 1'b1;
    if (sz == 2'd2 && (a % 2) != 0) b = 1'b1;
`else
    if (a == 32'hFFFF_FFFF) b = b; // alignment ignored in this build
`endif
    return b;
  endfunction

  function automatic int lane_shift(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd1) return 8 * int'(a % 4);
    if (sz == 2'd2) return 16 * int'((a / 2) % 2);
    return 0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] sz);
    if (sz == 2'd1) return 32'h0000_00FF;
    if (sz == 2'd2) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  // Advance the model one clock; latencies come from the state-path lengths.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; e_ack[i] = 1'b0; e_busy[i] = 1'b0;
        e_err[i] = 1'b0; e_rdata[i] = '0;
      end else begin
        e_ack[i] = 1'b0;
        e_err[i] = 1'b0;
        if (m_act[i]) begin
          m_t[i]++;
          if (m_t[i] == m_lat[i]) begin
            m_act[i] = 1'b0;
            e_ack[i] = 1'b1;
            e_err[i] = m_bad[i];
            if (!m_bad[i]) begin
              m_idx = int'((m_addr[i] / 4) % DEPTH);
              if (m_wr[i]) begin
                if (m_size[i] == 2'd0) m_mem[i][m_idx] = m_wd[i];
                else m_mem[i][m_idx] =
                  (m_mem[i][m_idx] & ~(lane_mask(m_size[i]) << lane_shift(m_size[i], m_addr[i]))) |
                  ((m_wd[i] & lane_mask(m_size[i])) << lane_shift(m_size[i], m_addr[i]));
              end else begin
                e_rdata[i] = (m_mem[i][m_idx] >> lane_shift(m_size[i], m_addr[i])) & lane_mask(m_size[i]);
              end
            end
          end
        end else if (e_busy[i]) begin
          e_busy[i] = 1'b0;
        end else if (req[i]) begin
          m_wr[i] = wr[i]; m_size[i] = size[i]; m_addr[i] = addr[i]; m_wd[i] = wdata[i];
          m_bad[i] = is_bad(size[i], addr[i]);
          if (m_bad[i])                         m_lat[i] = ws_of(i) + 1;
          else if (wr[i] && size[i] != 2'd0)    m_lat[i] = ws_of(i) + 4;
          else                                  m_lat[i] = ws_of(i) + 2;
          m_t[i] = 0; m_act[i] = 1'b1; e_busy[i] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ack[%0d]", i),   32'(ack[i]),  32'(e_ack[i]));
      chk($sformatf("busy[%0d]", i),  32'(busy[i]), 32'(e_busy[i]));
      chk($sformatf("rdata[%0d]", i), rdata[i],     e_rdata[i]);
      if (e_ack[i]) chk($sformatf("err[%0d]", i), 32'(err[i]), 32'(e_err[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int i, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic e);
    @(negedge clk);
    req[i] = 1'b1; wr[i] = w; size[i] = sz; addr[i] = a; wdata[i] = d;
    @(posedge clk);
    @(negedge clk);
    req[i] = 1'b0;
    lat = 0; rd = '0; e = 1'b0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (ack[i]) begin lat = n; rd = rdata[i]; e = err[i]; end
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout[%0d]: got no ack expected one within 40 cycles", i);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    int          acks;
    int          low_run;

    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd0; addr[i] = '0; wdata[i] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_ack",   32'(ack[0]),  32'h0);
    chk("rst_busy",  32'(busy[0]), 32'h0);
    chk("rst_err",   32'(err[0]),  32'h0);
    rst_n = 1'b1;

    // word write then read, two wait states
    txn(0, 1'b1, 2'd0, 32'h10, 32'hDEAD_BEEF, lat, rd, e);
    chk("wr_word_lat", 32'(lat), 32'd4);
    chk("wr_word_err", 32'(e), 32'd0);
    txn(0, 1'b0, 2'd0, 32'h10, 32'h0, lat, rd, e);
    chk("rd_word_lat",  32'(lat), 32'd4);
    chk("rd_word_data", rd, 32'hDEAD_BEEF);
    chk("rd_word_err",  32'(e), 32'd0);

    // byte read-modify-write
    txn(0, 1'b1, 2'd0, 32'h20, 32'h1122_3344, lat, rd, e);
    txn(0, 1'b1, 2'd1, 32'h22, 32'h0000_00AA, lat, rd, e);
    txn(0, 1'b0, 2'd0, 32'h20, 32'h0, lat, rd, e);
    chk("rmw_byte_word", rd, 32'h11AA_3344);
    txn(0, 1'b0, 2'd1, 32'h23, 32'h0, lat, rd, e);
    chk("rd_byte3", rd, 32'h0000_0011);

    // halfword store into the upper half, then halfword load
    txn(0, 1'b1, 2'd2, 32'h22, 32'h1234_BEEF, lat, rd, e);
    txn(0, 1'b0, 2'd2, 32'h22, 32'h0, lat, rd, e);
    chk("rd_half_hi", rd, 32'h0000_BEEF);

    // every byte lane of one word
    txn(0, 1'b1, 2'd0, 32'h30, 32'h0, lat, rd, e);
    for (int n = 0; n < 4; n++)
      txn(0, 1'b1, 2'd1, 32'h30 + 32'(n), 32'h10 + 32'(n), lat, rd, e);
    txn(0, 1'b0, 2'd0, 32'h30, 32'h0, lat, rd, e);
    chk("byte_lanes", rd, 32'h1312_1110);

    // address wrap-around
    txn(0, 1'b1, 2'd0, 32'h100, 32'hCAFE_F00D, lat, rd, e);
    txn(0, 1'b0, 2'd0, 32'h000, 32'h0, lat, rd, e);
    chk("wrap_read", rd, 32'hCAFE_F00D);

    // reserved size and unaligned halfword
    txn(0, 1'b1, 2'd0, 32'h04, 32'h89AB_CDEF, lat, rd, e);
    txn(0, 1'b0, 2'd3, 32'h04, 32'h0, lat, rd, e);
    chk("rsvd_err",   32'(e), 32'd1);
    chk("rsvd_rdata", rd, 32'hCAFE_F00D);
    txn(0, 1'b1, 2'd3, 32'h04, 32'h0BAD_0BAD, lat, rd, e);
    chk("rsvd_wr_err", 32'(e), 32'd1);
    txn(0, 1'b0, 2'd2, 32'h05, 32'h0, lat, rd, e);
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    chk("half05_err",   32'(e), 32'd1);
    chk("half05_rdata", rd, 32'hCAFE_F00D);
`else
    chk("half05_err",   32'(e), 32'd0);
    chk("half05_rdata", rd, 32'h0000_CDEF);
`endif
    txn(0, 1'b0, 2'd0, 32'h04, 32'h0, lat, rd, e);
    chk("rsvd_no_write", rd, 32'h89AB_CDEF);

    // reset during WAIT aborts an uncommitted write
    txn(0, 1'b1, 2'd0, 32'h08, 32'h0, lat, rd, e);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'd0; addr[0] = 32'h08; wdata[0] = 32'h5555_5555;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("abort_busy", 32'(busy[0]), 32'h0);
    chk("abort_rdata", rdata[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[0]) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    txn(0, 1'b0, 2'd0, 32'h08, 32'h0, lat, rd, e);
    chk("abort_mem", rd, 32'h0);

    // back-to-back requests with req held high, no wait states
    txn(1, 1'b1, 2'd0, 32'h40, 32'hA5A5_5A5A, lat, rd, e);
    chk("ws0_wr_lat", 32'(lat), 32'd2);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd0; addr[1] = 32'h40;
    acks = 0;
    low_run = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack[1]) acks++;
      if (!busy[1]) low_run++;
      else if (low_run != 0) begin
        chk("b2b_busy_gap", 32'(low_run), 32'd1);
        low_run = 0;
      end
    end
    req[1] = 1'b0;
    chk("b2b_acks",  32'(acks), 32'd5);
    chk("b2b_rdata", rdata[1], 32'hA5A5_5A5A);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
